// File: rtl/dmio_gen2_if.sv
// rtl/dmio_gen2_if.sv - word-addressed load/store bus between the datapath and dmio_gen2
interface dmio_gen2_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] direccion;
  logic [DATA_W-1:0] dataWrite;
  logic              memWr;
  logic              memRd;
  logic [DATA_W-1:0] dataRead;
  logic              rdValid;

  modport master (
    output direccion, dataWrite, memWr, memRd,
    input  dataRead, rdValid
  );

  modport slave (
    input  direccion, dataWrite, memWr, memRd,
    output dataRead, rdValid
  );
endinterface

// File: rtl/dmio_gen2.sv
// rtl/dmio_gen2.sv - data RAM plus memory-mapped LEDs, debounced switches, edge IRQ and cycle counter
module dmio_gen2 #(
  parameter int DATA_W     = 64,
  parameter int MEM_AW     = 12,
  parameter int SW_W       = 8,
  parameter int LED_W      = 8,
  parameter int N_LED_CH   = 2,
  parameter int DEB_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dmio_gen2_if.slave                bus,
  input  logic [SW_W-1:0]           sw,
  output logic [N_LED_CH*LED_W-1:0] lecturaLED,
  output logic                      irq
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  localparam logic [4:0] OFF_SW   = 5'h10;
  localparam logic [4:0] OFF_EDGE = 5'h11;
  localparam logic [4:0] OFF_MASK = 5'h12;
  localparam logic [4:0] OFF_CYC  = 5'h13;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              io_sel;
  logic [MEM_AW-1:0] ram_addr;
  logic [4:0]        io_off;
  logic              ram_we;
  logic              io_we;
  logic              unused_addr;

  assign io_sel      = bus.direccion[MEM_AW];
  assign ram_addr    = bus.direccion[MEM_AW-1:0];
  assign io_off      = bus.direccion[4:0];
  assign unused_addr = ^bus.direccion[DATA_W-1:MEM_AW+1];

  logic [N_LED_CH*LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0]           mask_q, mask_d;
  logic [SW_W-1:0]           edge_q, edge_d;
  logic [SW_W-1:0]           deb_q, deb_d;
  logic [SW_W-1:0]           sync1_q, sync1_d;
  logic [SW_W-1:0]           sync2_q, sync2_d;
  logic [CNT_W-1:0]          cnt_q [SW_W];
  logic [CNT_W-1:0]          cnt_d [SW_W];
  logic [DATA_W-1:0]         cyc_q, cyc_d;
  logic [DATA_W-1:0]         rd_data_q, rd_data_d;
  logic                      rd_valid_q, rd_valid_d;

  logic [SW_W-1:0]   edge_clr;
  logic [DATA_W-1:0] rd_mux;

  // rst_n gates the RAM strobe so an edge taken while reset is held never commits a write.
  always_comb begin
    ram_we = bus.memWr & ~io_sel & rst_n;
    io_we  = bus.memWr & io_sel;
  end

  always_comb begin
    sync1_d = sw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < SW_W; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = ~deb_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_comb begin
    led_d    = led_q;
    mask_d   = mask_q;
    edge_clr = '0;
    if (io_we) begin
      for (int k = 0; k < N_LED_CH; k++) begin
        if (io_off == 5'(k)) begin
          led_d[k*LED_W +: LED_W] = bus.dataWrite[LED_W-1:0];
        end
      end
      if (io_off == OFF_MASK) begin
        mask_d = bus.dataWrite[SW_W-1:0];
      end
      if (io_off == OFF_EDGE) begin
        edge_clr = bus.dataWrite[SW_W-1:0];
      end
    end
    // A fresh rising edge is OR-ed in after the clear so it survives a same-edge clear.
    edge_d = (edge_q & ~edge_clr) | (deb_d & ~deb_q);
    cyc_d  = cyc_q + DATA_W'(1);
  end

  always_comb begin
    rd_mux = '0;
    if (!io_sel) begin
      rd_mux = mem[ram_addr];
    end else begin
      for (int k = 0; k < N_LED_CH; k++) begin
        if (io_off == 5'(k)) begin
          rd_mux[LED_W-1:0] = led_q[k*LED_W +: LED_W];
        end
      end
      case (io_off)
        OFF_SW:   rd_mux[SW_W-1:0] = deb_q;
        OFF_EDGE: rd_mux[SW_W-1:0] = edge_q;
        OFF_MASK: rd_mux[SW_W-1:0] = mask_q;
        OFF_CYC:  rd_mux           = cyc_q;
        default:  ;
      endcase
    end
    rd_valid_d = bus.memRd;
    rd_data_d  = bus.memRd ? rd_mux : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= bus.dataWrite;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q      <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      deb_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      cyc_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < SW_W; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      led_q      <= led_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      deb_q      <= deb_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cyc_q      <= cyc_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      for (int i = 0; i < SW_W; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.dataRead = rd_data_q;
  assign bus.rdValid  = rd_valid_q;
  assign lecturaLED   = led_q;
  assign irq          = |(edge_q & mask_q);

endmodule

// File: doc/dmio_gen2.md
# dmio_gen2

Second-generation data-memory / memory-mapped I/O block for the single-cycle datapath. Holds a parametrised data RAM and a small I/O register file selected by one address bit. The I/O side adds multi-channel LED outputs, synchronised and debounced switch inputs, sticky rising-edge capture with a maskable interrupt, and a free-running cycle counter. Writes are synchronous and reads are registered (1-cycle latency).

## Interface
- DATA_W, 64, data and address word width
- MEM_AW, 12, RAM address bits; RAM depth = 2**MEM_AW words; bit MEM_AW of `direccion` selects I/O
- SW_W, 8, switch input width (SW_W ≤ DATA_W)
- LED_W, 8, bits per LED channel (LED_W ≤ DATA_W)
- N_LED_CH, 2, LED channels (1..16)
- DEB_CYCLES, 4, debounce stability cycles (≥1)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- direccion  in  DATA_W  word address; bits above MEM_AW ignored
- dataWrite  in  DATA_W  write data
- memWr  in  1  write strobe
- memRd  in  1  read strobe
- sw  in  SW_W  asynchronous switch inputs
- dataRead  out  DATA_W  registered read data
- rdValid  out  1  dataRead updated this cycle
- lecturaLED  out  N_LED_CH*LED_W  LED registers; channel k at bits [k*LED_W +: LED_W]
- irq  out  1  OR of (edgeCap & irqMask)

## Operation
- Region select: `direccion[MEM_AW]` = 0 → RAM at `direccion[MEM_AW-1:0]`; = 1 → I/O at offset `direccion[4:0]`.
- I/O map, word offsets:
  - 0x00..N_LED_CH-1: LED channel, R/W, low LED_W bits.
  - 0x10: debounced switches, RO, zero-extended.
  - 0x11: edgeCap, sticky per-bit rising edge of the debounced switches. Read returns the value; write-1-to-clear.
  - 0x12: irqMask, R/W, SW_W bits.
  - 0x13: cycle counter, RO, DATA_W bits, +1 every cycle, wraps to 0.
  - Unmapped offsets: reads return 0; writes are ignored.
- Writes: committed on the rising edge with memWr=1. LED/mask writes take the low bits; the upper bits are dropped.
- Reads: memRd=1 at edge N → dataRead and rdValid=1 after edge N. With memRd=0, rdValid=0 and dataRead holds its last value.
- Switch path:
  - sw passes through a 2-flop synchroniser.
  - A per-bit counter increments while the synchronised bit differs from the debounced bit, and clears when they match.
  - When the counter reaches DEB_CYCLES, the debounced bit toggles and the counter clears.
- edgeCap bit sets on the same edge its debounced bit goes 0→1.
- Reset values: lecturaLED 0, dataRead 0, rdValid 0, irq 0, edgeCap 0, irqMask 0, debounced 0, synchronisers 0, debounce counters 0, cycle counter 0.
- RAM contents are not reset; simulation initialises them to 0.

## Timing
- Read latency is 1 cycle. Back-to-back reads are allowed every cycle.
- memRd and memWr to the same address in the same cycle: the read returns the old data; the write lands.
- Read of 0x11 with a simultaneous clear: the read returns the pre-clear value.
- Edge set and write-1-to-clear on the same bit in the same edge: set wins.
- Cycle counter read: returns the value held before edge N (the pre-increment value at the issuing edge).
- Switch latency: a stable level change on sw reaches the debounced register at edge 2+DEB_CYCLES after it is first sampled.
  - A glitch shorter than DEB_CYCLES synchronised cycles produces no change.
- irq is combinational from registers. It rises in the same cycle edgeCap sets (if masked-in) and falls in the cycle after the clear edge.
- Reset assert mid-operation: all registers clear immediately. A pending read is discarded (rdValid=0). The RAM write on that edge is not performed.

## Test plan
- Reset, then write 0xDEADBEEF_00000001 to RAM 0x005 and read 0x005 → dataRead = written value, rdValid=1 one cycle after memRd; read 0xFFF after writing 0xFFF → correct top-word access.
- Simultaneous memRd+memWr to RAM 0x010 (old 0x11, new 0x22) → dataRead=0x11; next read → 0x22.
- Write 0x1A5 to I/O 0x00 and 0x3C to 0x01 → lecturaLED = {0x3C, 0xA5}; readback returns 0xA5 / 0x3C; write to offset 0x1F → no state change, read 0.
- With DEB_CYCLES=4:
  - sw[0] 1-cycle pulse → debounced stays 0.
  - sw[0] held high → 0x10 reads 0x01 from edge 6 onward; edgeCap[0]=1.
  - irqMask=0x01 → irq=1.
  - Write 0x01 to 0x11 → irq=0 next cycle.
- Edge on sw[1] completing debounce on the same edge as a write-1-to-clear of bit 1 → edgeCap[1] remains 1.
- Read 0x13 at two edges 10 cycles apart → difference 10; assert rst_n low mid-sequence → all outputs 0 asynchronously and the counter restarts from 0.
